// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Sequential instruction fetch into a DEPTH-entry FIFO with a
//            valid/stall handshake towards decode and redirect flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_buffer #(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable_fetch,
    input  logic                    stall,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_enable,
    output logic                    mem_rw,
    output logic [1:0]              mem_access_size,
    input  logic                    mem_busy,
    input  logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic                    insn_valid,
    output logic [DATA_WIDTH-1:0]   insn,
    output logic [ADDR_WIDTH-1:0]   insn_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic                  r_inflight;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];

    logic w_credit;
    logic w_accept;
    logic w_push;
    logic w_pop;

    // Outstanding request reserves a slot, so a response can never overflow.
    assign w_credit = ({1'b0, r_count} + {{CW{1'b0}}, r_inflight}) < C_DEPTH;

    assign mem_enable      = enable_fetch & ~reset & ~redirect_valid & w_credit;
    assign mem_address     = r_pc;
    assign mem_rw          = 1'b1;
    assign mem_access_size = 2'b00;

    assign w_accept = mem_enable & ~mem_busy;
    assign w_push   = r_inflight;
    assign w_pop    = insn_valid & ~stall;

    assign insn_valid = (r_count != '0);
    assign insn       = r_data[r_rd_ptr];
    assign insn_pc    = r_addr[r_rd_ptr];
    assign count      = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= START_ADDR;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_data[i] <= '0;
                r_addr[i] <= '0;
            end
        end else if (redirect_valid) begin
            // The word still returning from memory belongs to the old path.
            r_pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_pc      <= r_pc + ADDR_WIDTH'(4);
                r_resp_pc <= r_pc;
            end
            r_inflight <= w_accept;
            if (w_push) begin
                r_data[r_wr_ptr] <= mem_data_out;
                r_addr[r_wr_ptr] <= r_resp_pc;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

`default_nettype wire
